// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM encoding
// and the debounce counter width.
package button_conditioner_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Counter stops at all-ones rather than wrapping back into a "fresh" count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw active-low buttons and enable in, press pulses and
// debounced held levels out. WIDTH is the number of channels carried.
interface button_conditioner_if #(parameter int WIDTH = 1);

  logic [WIDTH-1:0] btn;
  logic             enable;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] held;

  modport master (output btn, enable, input press, held);
  modport slave  (input btn, enable, output press, held);

endinterface

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with saturating
// counter, registered one-shot press pulse and held level.
//   state           | meaning
//   ST_RELEASED     | accepted as released, watching for a low sample
//   ST_PRESS_WAIT   | low seen, counting stable low samples
//   ST_PRESSED      | accepted as pressed, watching for a high sample
//   ST_RELEASE_WAIT | high seen, counting stable high samples
module btn_debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk_sys,
  input  logic                  rst_b,
  button_conditioner_if.slave   ch
);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic             btn_sync;
  btn_state_e       state_q;
  btn_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;
  logic             press_q;
  logic             held_q;

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], ch.btn[0]};
    end
  end

  assign btn_sync = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (!btn_sync) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_PRESS_WAIT: begin
        if (btn_sync) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LIM) begin
          state_d = ST_PRESSED;
          accept  = 1'b1;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_PRESSED: begin
        if (btn_sync) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = 8'd1;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!btn_sync) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == DEB_LIM) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Enable is only looked at on the accepting edge, so a gated press is lost for good.
  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= accept & ch.enable;
      held_q  <= (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end
  end

  assign ch.press[0] = press_q;
  assign ch.held[0]  = held_q;

endmodule

// File: rtl/button_conditioner.sv
// Top: NUM_BTN independent debounce channels sharing clock, reset and enable.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_BTN         = 3
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn,
  input  logic               i_enable,
  output logic [NUM_BTN-1:0] o_press,
  output logic [NUM_BTN-1:0] o_held
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    button_conditioner_if #(.WIDTH(1)) ch_if ();

    assign ch_if.btn[0]  = i_btn[g];
    assign ch_if.enable  = i_enable;

    btn_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_channel (
      .clk_sys (i_clock),
      .rst_b   (i_reset),
      .ch      (ch_if)
    );

    assign o_press[g] = ch_if.press[0];
    assign o_held[g]  = ch_if.held[0];
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: run-length debounce model checked every cycle, plus
// directed scenarios with hand-computed latencies and pulse counts.
module tb_button_conditioner;

  localparam int D   = 3;
  localparam int NB  = 3;
  localparam int LAT = 2 + D + 1;

  logic clk = 1'b0;
  logic rst;

  button_conditioner_if #(.WIDTH(NB)) bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .NUM_BTN         (NB)
  ) dut (
    .i_clock  (clk),
    .i_reset  (rst),
    .i_btn    (bus.btn),
    .i_enable (bus.enable),
    .o_press  (bus.press),
    .o_held   (bus.held)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit chk_on = 1'b0;

  // Model: synchronizer as a two-deep delay of raw samples; acceptance when a
  // level differing from the accepted one has been seen D+1 samples in a row.
  logic [NB-1:0] m_p0 = '1;
  logic [NB-1:0] m_p1 = '1;
  logic [NB-1:0] m_acc = '0;
  logic [NB-1:0] exp_press = '0;
  logic [NB-1:0] exp_held = '0;
  logic          m_lvl;
  int            m_run[NB];

  always @(posedge clk) begin
    if (!rst) begin
      m_p0 = '1;
      m_p1 = '1;
      m_acc = '0;
      exp_press = '0;
      exp_held = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        m_lvl = ~m_p1[i];
        exp_press[i] = 1'b0;
        if (m_lvl != m_acc[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 0;
        if (m_run[i] == D + 1) begin
          m_acc[i] = m_lvl;
          m_run[i] = 0;
          exp_press[i] = m_lvl & bus.enable;
        end
      end
      exp_held = m_acc;
      m_p1 = m_p0;
      m_p0 = bus.btn;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_cmp++;
      if (bus.press !== exp_press || bus.held !== exp_held) begin
        n_mis++;
        $display("FAIL model t=%0t press=%b held=%b required press=%b held=%b",
                 $time, bus.press, bus.held, exp_press, exp_held);
      end
    end
  end

  int pulses[NB];
  initial for (int i = 0; i < NB; i++) pulses[i] = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NB; i++) if (bus.press[i] === 1'b1) pulses[i]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_mis++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic wait_press(input int ch, output int k);
    k = 0;
    while (k < 20 && bus.press[ch] !== 1'b1) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_held_low(input int ch, output int k);
    k = 0;
    while (k < 20 && bus.held[ch] !== 1'b0) begin
      tick();
      k++;
    end
  endtask

  int k;
  int b;
  int h;
  int hold_left[NB];

  initial begin
    rst = 1'b0;
    bus.btn = '1;
    bus.enable = 1'b1;
    tick();
    chk_on = 1'b1;
    repeat (2) tick();
    check("reset_press", int'(bus.press), 0);
    check("reset_held", int'(bus.held), 0);
    rst = 1'b1;
    repeat (4) tick();

    // clean press on btn0, held 20 cycles
    b = pulses[0];
    bus.btn[0] = 1'b0;
    wait_press(0, k);
    check("clean_latency", k, LAT);
    check("clean_held_at_press", int'(bus.held[0]), 1);
    tick();
    check("clean_pulse_width", int'(bus.press[0]), 0);
    repeat (20 - k - 1) tick();
    bus.btn[0] = 1'b1;
    wait_held_low(0, k);
    check("clean_release_latency", k, LAT);
    check("clean_pulse_count", pulses[0] - b, 1);
    repeat (4) tick();

    // bounce on btn1: low 2, high 1, low 10
    b = pulses[1];
    bus.btn[1] = 1'b0;
    repeat (2) tick();
    bus.btn[1] = 1'b1;
    tick();
    bus.btn[1] = 1'b0;
    wait_press(1, k);
    check("bounce_latency", k, LAT);
    repeat (4) tick();
    bus.btn[1] = 1'b1;
    repeat (10) tick();
    check("bounce_pulse_count", pulses[1] - b, 1);

    // 2-cycle glitch on btn2
    b = pulses[2];
    h = 0;
    bus.btn[2] = 1'b0;
    repeat (2) tick();
    bus.btn[2] = 1'b1;
    repeat (12) begin
      tick();
      if (bus.held[2] !== 1'b0) h = 1;
    end
    check("glitch_pulse_count", pulses[2] - b, 0);
    check("glitch_held_seen", h, 0);

    // enable gating: accepted while disabled, enabled later while still held
    b = pulses[0];
    bus.enable = 1'b0;
    bus.btn[0] = 1'b0;
    repeat (10) tick();
    check("gated_held", int'(bus.held[0]), 1);
    bus.enable = 1'b1;
    repeat (10) tick();
    check("gated_pulse_count", pulses[0] - b, 0);
    bus.btn[0] = 1'b1;
    repeat (10) tick();

    // simultaneous press on all channels
    bus.btn = '0;
    wait_press(0, k);
    check("simul_latency", k, LAT);
    check("simul_vector", int'(bus.press), 7);
    repeat (5) tick();
    bus.btn = '1;
    repeat (10) tick();

    // reset during PRESS_WAIT aborts; button kept low is a new press afterwards
    b = pulses[0];
    bus.btn[0] = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    check("rst_abort_pulse_count", pulses[0] - b, 0);
    check("rst_held", int'(bus.held[0]), 0);
    rst = 1'b1;
    wait_press(0, k);
    check("rst_release_latency", k, LAT);
    check("rst_pulse_count", pulses[0] - b, 1);
    bus.btn[0] = 1'b1;
    repeat (10) tick();

    // randomized bouncing buttons, enable toggles, occasional reset
    for (int i = 0; i < NB; i++) hold_left[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < NB; i++) begin
        if (hold_left[i] == 0) begin
          bus.btn[i] = ~bus.btn[i];
          hold_left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 30)
                                                      : $urandom_range(1, 6);
        end else begin
          hold_left[i]--;
        end
      end
      if ($urandom_range(0, 24) == 0) bus.enable = ~bus.enable;
      rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst = 1'b1;
    bus.btn = '1;
    repeat (12) tick();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
